// File: rtl/counter_pkg.sv
// counter_pkg: shared direction constants and load clamping for the counter collection
package counter_pkg;
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;
  function automatic logic [16:0] clamp_load(input logic [16:0] d, input logic [16:0] modulus);
    return (d >= modulus) ? modulus - 17'd1 : d;
  endfunction
endpackage

// File: rtl/counter_next_val.sv
// counter_next_val: next count, wrap and terminal-count logic (saturating when UPDOWN_COUNTER_SAT_EN is defined)
module counter_next_val
  import counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MODULUS = 8
) (
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_nxt,
  output logic             wrap_nxt,
  output logic             tc
);
  localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);
  logic [WIDTH:0] q_ext, up_val, dn_val, ld_val;
  logic at_max, at_zero, wrap_step;
  // one-step move in WIDTH+1 bits so MODULUS = 2**WIDTH cannot overflow
  always_comb begin
    q_ext = {1'b0, q};
    at_max = q_ext == MAX;
    at_zero = q_ext == '0;
    ld_val = (WIDTH+1)'(clamp_load(17'(d), 17'(MODULUS)));
`ifdef UPDOWN_COUNTER_SAT_EN
    up_val = at_max ? MAX : q_ext + 1'b1;
    dn_val = at_zero ? '0 : q_ext - 1'b1;
    wrap_step = 1'b0;
`else
    up_val = at_max ? '0 : q_ext + 1'b1;
    dn_val = at_zero ? MAX : q_ext - 1'b1;
    wrap_step = (up_dn == CNT_UP) ? at_max : at_zero;
`endif
    q_nxt = !reset ? '0 : load ? WIDTH'(ld_val) : en ? WIDTH'((up_dn == CNT_UP) ? up_val : dn_val) : q;
    wrap_nxt = reset & ~load & en & wrap_step;
    tc = reset & en & ~load & ((up_dn == CNT_UP) ? at_max : at_zero);
  end
endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: synchronous up/down modulo counter with load, tc and wrap (UPDOWN_COUNTER_SAT_EN selects saturation)
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MODULUS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             wrap
);
  logic [WIDTH-1:0] q_nxt;
  logic wrap_nxt;
  counter_next_val #(.WIDTH(WIDTH), .MODULUS(MODULUS)) u_next (
    .reset(reset), .en(en), .up_dn(up_dn), .load(load), .d(d), .q(Q),
    .q_nxt(q_nxt), .wrap_nxt(wrap_nxt), .tc(tc)
  );
  // count and wrap registers update together; reset is folded into q_nxt/wrap_nxt
  always_ff @(posedge clk) begin
    Q <= q_nxt;
    wrap <= wrap_nxt;
  end
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: table-driven check of modulus-8 and modulus-6 counters
module tb_updown_mod_counter;
  typedef struct {
    bit sel;
    bit r, e, u, l;
    logic [2:0] d;
    bit tc;
    logic [2:0] q;
    bit w;
  } vec_t;
  logic clk = 0;
  logic rst [2];
  logic en [2];
  logic up [2];
  logic ld [2];
  logic [2:0] d [2];
  logic [2:0] q [2];
  logic tc [2];
  logic w [2];
  int vectors = 0;
  int errors = 0;
  vec_t tv [$];
  always #5 clk = ~clk;
  updown_mod_counter #(.WIDTH(3), .MODULUS(8)) u8 (
    .clk(clk), .reset(rst[0]), .en(en[0]), .up_dn(up[0]), .load(ld[0]), .d(d[0]),
    .Q(q[0]), .tc(tc[0]), .wrap(w[0])
  );
  updown_mod_counter #(.WIDTH(3), .MODULUS(6)) u6 (
    .clk(clk), .reset(rst[1]), .en(en[1]), .up_dn(up[1]), .load(ld[1]), .d(d[1]),
    .Q(q[1]), .tc(tc[1]), .wrap(w[1])
  );
  task automatic run(input vec_t v, input int idx);
    @(negedge clk);
    rst[v.sel] = v.r;
    en[v.sel] = v.e;
    up[v.sel] = v.u;
    ld[v.sel] = v.l;
    d[v.sel] = v.d;
    #1;
    vectors++;
    if (tc[v.sel] !== v.tc) begin
      errors++;
      $display("FAIL tc vec%0d m%0d: got %b want %b", idx, v.sel ? 6 : 8, tc[v.sel], v.tc);
    end
    @(posedge clk);
    #1;
    if (q[v.sel] !== v.q) begin
      errors++;
      $display("FAIL Q vec%0d m%0d: got %0d want %0d", idx, v.sel ? 6 : 8, q[v.sel], v.q);
    end
    if (w[v.sel] !== v.w) begin
      errors++;
      $display("FAIL wrap vec%0d m%0d: got %b want %b", idx, v.sel ? 6 : 8, w[v.sel], v.w);
    end
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 0; en[i] = 0; up[i] = 1; ld[i] = 0; d[i] = 0;
    end
    // modulus 8: reset with en high, then count up through the wrap
    tv.push_back('{0, 0, 1, 1, 0, 3'd0, 0, 3'd0, 0});
    tv.push_back('{0, 0, 1, 1, 0, 3'd0, 0, 3'd0, 0});
    for (int i = 1; i <= 7; i++) tv.push_back('{0, 1, 1, 1, 0, 3'd0, 0, 3'(i), 0});
    tv.push_back('{0, 1, 1, 1, 0, 3'd0, 1, 3'd0, 1});
    tv.push_back('{0, 1, 1, 1, 0, 3'd0, 0, 3'd1, 0});
    // load overrides en, then direction toggling at 4
    tv.push_back('{0, 1, 1, 1, 1, 3'd3, 0, 3'd3, 0});
    tv.push_back('{0, 1, 1, 1, 0, 3'd0, 0, 3'd4, 0});
    tv.push_back('{0, 1, 1, 1, 0, 3'd0, 0, 3'd5, 0});
    tv.push_back('{0, 1, 1, 0, 0, 3'd0, 0, 3'd4, 0});
    tv.push_back('{0, 1, 1, 1, 0, 3'd0, 0, 3'd5, 0});
    tv.push_back('{0, 1, 1, 0, 0, 3'd0, 0, 3'd4, 0});
    tv.push_back('{0, 1, 0, 0, 0, 3'd0, 0, 3'd4, 0});
    // wrap is a single-cycle pulse, tc needs en
    tv.push_back('{0, 1, 1, 1, 1, 3'd7, 0, 3'd7, 0});
    tv.push_back('{0, 1, 1, 1, 0, 3'd0, 1, 3'd0, 1});
    tv.push_back('{0, 1, 0, 0, 0, 3'd0, 0, 3'd0, 0});
    tv.push_back('{0, 1, 1, 0, 0, 3'd0, 1, 3'd7, 1});
    tv.push_back('{0, 1, 1, 0, 0, 3'd0, 0, 3'd6, 0});
    // reset beats load and en at Q=7
    tv.push_back('{0, 1, 1, 1, 1, 3'd7, 0, 3'd7, 0});
    tv.push_back('{0, 0, 1, 1, 1, 3'd6, 0, 3'd0, 0});
    tv.push_back('{0, 1, 0, 1, 0, 3'd0, 0, 3'd0, 0});
    // modulus 6: count down and wrap to 5
    tv.push_back('{1, 0, 1, 0, 0, 3'd0, 0, 3'd0, 0});
    tv.push_back('{1, 1, 1, 0, 0, 3'd0, 1, 3'd5, 1});
    for (int i = 4; i >= 0; i--) tv.push_back('{1, 1, 1, 0, 0, 3'd0, 0, 3'(i), 0});
    tv.push_back('{1, 1, 1, 0, 0, 3'd0, 1, 3'd5, 1});
    // load clamping at and above the modulus, up wrap at 5
    tv.push_back('{1, 1, 1, 1, 1, 3'd7, 0, 3'd5, 0});
    tv.push_back('{1, 1, 1, 1, 0, 3'd0, 1, 3'd0, 1});
    tv.push_back('{1, 1, 0, 1, 1, 3'd6, 0, 3'd5, 0});
    tv.push_back('{1, 1, 0, 1, 1, 3'd4, 0, 3'd4, 0});
    tv.push_back('{1, 1, 1, 1, 1, 3'd5, 0, 3'd5, 0});
    foreach (tv[i]) run(tv[i], i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
